irq_sched_ctrl: RTL and testbench

//  Interrupt scheduler in front of the interrupt monitor. It arbitrates the 14 masked IRQ

---
 rtl/irq_sched_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_irq_sched_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_sched_ctrl
// Brief    : Priority IRQ scheduler: one-hot grant, ack wait, delayed jump pulse,
//            active-ISR tracking. Define IRQ_NEST_EN to enable ISR preemption.
// Revision : 1.0
// ============================================================================
module irq_sched_ctrl #(
    parameter int NIRQ        = 14,
    parameter int JMP_DELAY   = 4,
    parameter int ACK_TIMEOUT = 15,
    parameter int NEST_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            puc_rst,
    input  logic [NIRQ-1:0] irq_req,
    input  logic [NIRQ-1:0] irq_mask,
    input  logic            gie,
    input  logic            irq_ack,
    input  logic            reti,
    output logic [NIRQ-1:0] irq_acc,
    output logic            irq_jmp,
    output logic [3:0]      irq_vec,
    output logic            irq_busy,
    output logic [3:0]      nest_depth,
    output logic            timeout_err
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_GRANT  = 3'd1;
    localparam logic [2:0] c_DELAY  = 3'd2;
    localparam logic [2:0] c_JUMP   = 3'd3;
    localparam logic [2:0] c_ACTIVE = 3'd4;

    localparam logic [7:0] c_ACK_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] c_JMP_LAST = 8'(JMP_DELAY - 1);
`ifdef IRQ_NEST_EN
    localparam logic [3:0] c_MAX_DEPTH = 4'(NEST_DEPTH);
`else
    localparam logic [3:0] c_MAX_DEPTH = 4'd1;
`endif

    logic [2:0]      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [NIRQ-1:0] acc_q, acc_d;
    logic [3:0]      vec_q, vec_d;
    logic [3:0]      depth_q, depth_d;
    logic            terr_q, terr_d;

    logic [NIRQ-1:0] eligible;
    logic [3:0]      winner;
    logic [NIRQ-1:0] winner_onehot;
    logic            req_valid;
    logic            preempt;

    assign eligible      = irq_req & irq_mask;
    assign req_valid     = gie && (|eligible);
    assign winner_onehot = NIRQ'(1) << winner;

    // Highest set index wins: later iterations overwrite lower ones.
    always_comb begin
        winner = '0;
        for (int i = 0; i < NIRQ; i++) begin
            if (eligible[i]) winner = 4'(i);
        end
    end

`ifdef IRQ_NEST_EN
    logic [NEST_DEPTH-1:0][3:0] stack_q, stack_d;
    logic [3:0]                 top_reti, top_tmo;

    // On reti the preempted vector sits one below the current depth; on a
    // nested timeout depth has not yet grown, so it sits at depth-1.
    always_comb begin
        top_reti = '0;
        top_tmo  = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (i == int'(depth_q) - 2) top_reti = stack_q[i];
            if (i == int'(depth_q) - 1) top_tmo  = stack_q[i];
        end
    end

    assign preempt = req_valid && (winner > vec_q) && (depth_q < c_MAX_DEPTH);
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q <= c_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            vec_q   <= '0;
            depth_q <= '0;
            terr_q  <= 1'b0;
`ifdef IRQ_NEST_EN
            stack_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            vec_q   <= vec_d;
            depth_q <= depth_d;
            terr_q  <= terr_d;
`ifdef IRQ_NEST_EN
            stack_q <= stack_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (req_valid) state_d = c_GRANT;
            end
            c_GRANT: begin
                if (irq_ack) begin
                    state_d = (JMP_DELAY == 1) ? c_JUMP : c_DELAY;
                end else if (cnt_q == c_ACK_LAST) begin
                    state_d = (depth_q != 4'd0) ? c_ACTIVE : c_IDLE;
                end
            end
            c_DELAY: begin
                if (cnt_q >= c_JMP_LAST) state_d = c_JUMP;
            end
            c_JUMP: begin
                state_d = c_ACTIVE;
            end
            c_ACTIVE: begin
                if (reti) begin
                    state_d = (depth_q <= 4'd1) ? c_IDLE : c_ACTIVE;
                end else if (preempt) begin
                    state_d = c_GRANT;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        vec_d   = vec_q;
        depth_d = depth_q;
        terr_d  = terr_q;
`ifdef IRQ_NEST_EN
        stack_d = stack_q;
`endif
        case (state_q)
            c_IDLE: begin
                if (req_valid) begin
                    acc_d = winner_onehot;
                    vec_d = winner;
                    cnt_d = '0;
                end
            end
            c_GRANT: begin
                if (irq_ack) begin
                    acc_d = '0;
                    cnt_d = 8'd1;
                end else if (cnt_q == c_ACK_LAST) begin
                    acc_d  = '0;
                    terr_d = 1'b1;
`ifdef IRQ_NEST_EN
                    if (depth_q != 4'd0) vec_d = top_tmo;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            c_DELAY: begin
                if (cnt_q < c_JMP_LAST) cnt_d = cnt_q + 8'd1;
            end
            c_JUMP: begin
                if (depth_q < c_MAX_DEPTH) depth_d = depth_q + 4'd1;
            end
            c_ACTIVE: begin
                if (reti) begin
                    if (depth_q != 4'd0) depth_d = depth_q - 4'd1;
`ifdef IRQ_NEST_EN
                    if (depth_q > 4'd1) vec_d = top_reti;
`endif
                end else if (preempt) begin
`ifdef IRQ_NEST_EN
                    for (int i = 0; i < NEST_DEPTH; i++) begin
                        if (i == int'(depth_q) - 1) stack_d[i] = vec_q;
                    end
`endif
                    acc_d = winner_onehot;
                    vec_d = winner;
                    cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        irq_acc     = acc_q;
        irq_jmp     = (state_q == c_JUMP);
        irq_vec     = vec_q;
        irq_busy    = (state_q != c_IDLE);
        nest_depth  = depth_q;
        timeout_err = terr_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_sched_ctrl
// Brief    : Directed self-checking bench for irq_sched_ctrl.
// Revision : 1.0
// ============================================================================
module tb_irq_sched_ctrl;

    logic        clk = 1'b0;
    logic        puc_rst = 1'b1;
    logic [13:0] irq_req = '0;
    logic [13:0] irq_mask = '1;
    logic        gie = 1'b0;
    logic        irq_ack = 1'b0;
    logic        reti = 1'b0;
    logic [13:0] irq_acc;
    logic        irq_jmp;
    logic [3:0]  irq_vec;
    logic        irq_busy;
    logic [3:0]  nest_depth;
    logic        timeout_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    irq_sched_ctrl dut (
        .clk         (clk),
        .puc_rst     (puc_rst),
        .irq_req     (irq_req),
        .irq_mask    (irq_mask),
        .gie         (gie),
        .irq_ack     (irq_ack),
        .reti        (reti),
        .irq_acc     (irq_acc),
        .irq_jmp     (irq_jmp),
        .irq_vec     (irq_vec),
        .irq_busy    (irq_busy),
        .nest_depth  (nest_depth),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From a GRANT cycle: ack, then DELAY x3, JUMP, land in ACTIVE.
    task automatic run_to_active();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        #1;
        chk("rst_acc",   32'(irq_acc), 32'h0);
        chk("rst_jmp",   32'(irq_jmp), 32'h0);
        chk("rst_vec",   32'(irq_vec), 32'h0);
        chk("rst_busy",  32'(irq_busy), 32'h0);
        chk("rst_depth", 32'(nest_depth), 32'h0);
        chk("rst_terr",  32'(timeout_err), 32'h0);
        tick();
        puc_rst = 1'b0;

        // Single request on line 5, full handshake.
        gie = 1'b1;
        irq_req = 14'h0020;
        tick();
        chk("t1_acc",  32'(irq_acc), 32'h0020);
        chk("t1_vec",  32'(irq_vec), 32'd5);
        chk("t1_busy", 32'(irq_busy), 32'h1);
        irq_req = '0;
        tick();
        chk("t1_acc_held", 32'(irq_acc), 32'h0020);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t1_acc_clr", 32'(irq_acc), 32'h0);
        chk("t1_jmp_t1",  32'(irq_jmp), 32'h0);
        tick();
        tick();
        chk("t1_jmp_t3",  32'(irq_jmp), 32'h0);
        tick();
        chk("t1_jmp_t4",  32'(irq_jmp), 32'h1);
        tick();
        chk("t1_jmp_t5",  32'(irq_jmp), 32'h0);
        chk("t1_depth",   32'(nest_depth), 32'd1);
        chk("t1_vec_act", 32'(irq_vec), 32'd5);
`ifndef IRQ_NEST_EN
        irq_req = 14'h0200;
        tick();
        tick();
        chk("t1_no_preempt", 32'(irq_acc), 32'h0);
        irq_req = '0;
`endif
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t1_stray_ack", 32'(nest_depth), 32'd1);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("t1_reti_busy",  32'(irq_busy), 32'h0);
        chk("t1_reti_depth", 32'(nest_depth), 32'd0);

        // Simultaneous requests: 11 beats 0 and 2.
        irq_req = 14'h0805;
        tick();
        chk("t2_acc", 32'(irq_acc), 32'h0800);
        chk("t2_vec", 32'(irq_vec), 32'd11);
        run_to_active();
        chk("t2_depth", 32'(nest_depth), 32'd1);
        irq_req = 14'h0005;
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("t2_idle_acc", 32'(irq_acc), 32'h0);
        tick();
        chk("t2_acc2", 32'(irq_acc), 32'h0004);
        chk("t2_vec2", 32'(irq_vec), 32'd2);
        run_to_active();

        // reti and new request in the same cycle: reti wins.
        irq_req = 14'h0080;
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("t6_busy",  32'(irq_busy), 32'h0);
        chk("t6_depth", 32'(nest_depth), 32'd0);
        chk("t6_acc0",  32'(irq_acc), 32'h0);
        tick();
        chk("t6_acc",   32'(irq_acc), 32'h0080);
        chk("t6_vec",   32'(irq_vec), 32'd7);

        // No ack: 15 grant cycles, dropped on the 16th.
        gie = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("t3_acc_c15",  32'(irq_acc), 32'h0080);
        chk("t3_terr_c15", 32'(timeout_err), 32'h0);
        tick();
        chk("t3_acc_c16",  32'(irq_acc), 32'h0);
        chk("t3_terr",     32'(timeout_err), 32'h1);
        chk("t3_busy",     32'(irq_busy), 32'h0);
        tick();
        tick();
        tick();
        chk("t3_gie_off_acc",  32'(irq_acc), 32'h0);
        chk("t3_gie_off_busy", 32'(irq_busy), 32'h0);
        chk("t3_terr_sticky",  32'(timeout_err), 32'h1);

        // Reset during DELAY.
        gie = 1'b1;
        tick();
        chk("t4_acc", 32'(irq_acc), 32'h0080);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tick();
        chk("t4_busy_delay", 32'(irq_busy), 32'h1);
        #2;
        puc_rst = 1'b1;
        #1;
        chk("t4_rst_acc",   32'(irq_acc), 32'h0);
        chk("t4_rst_busy",  32'(irq_busy), 32'h0);
        chk("t4_rst_vec",   32'(irq_vec), 32'h0);
        chk("t4_rst_terr",  32'(timeout_err), 32'h0);
        chk("t4_rst_depth", 32'(nest_depth), 32'h0);
        tick();
        tick();
        chk("t4_no_jmp", 32'(irq_jmp), 32'h0);
        puc_rst = 1'b0;
        tick();
        chk("t4_regrant_acc", 32'(irq_acc), 32'h0080);
        chk("t4_regrant_vec", 32'(irq_vec), 32'd7);

        // Masked line never arbitrates.
        run_to_active();
        irq_mask = 14'h3F7F;
        reti = 1'b1;
        tick();
        reti = 1'b0;
        tick();
        tick();
        chk("mask_busy", 32'(irq_busy), 32'h0);
        chk("mask_acc",  32'(irq_acc), 32'h0);
        irq_req = '0;
        irq_mask = '1;

`ifdef IRQ_NEST_EN
        // Preemption of ISR 3 by 9; 1 stays pending.
        irq_req = 14'h0008;
        tick();
        chk("t5_acc3", 32'(irq_acc), 32'h0008);
        run_to_active();
        irq_req = 14'h0208;
        tick();
        chk("t5_acc9", 32'(irq_acc), 32'h0200);
        chk("t5_vec9", 32'(irq_vec), 32'd9);
        run_to_active();
        chk("t5_depth2", 32'(nest_depth), 32'd2);
        irq_req = 14'h0008;
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("t5_pop_vec",   32'(irq_vec), 32'd3);
        chk("t5_pop_depth", 32'(nest_depth), 32'd1);
        irq_req = 14'h000A;
        tick();
        tick();
        chk("t5_pending_acc",   32'(irq_acc), 32'h0);
        chk("t5_pending_depth", 32'(nest_depth), 32'd1);
        irq_req = 14'h0002;
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("t5_idle", 32'(irq_busy), 32'h0);
        tick();
        chk("t5_acc1", 32'(irq_acc), 32'h0002);
        irq_req = '0;
        run_to_active();
        reti = 1'b1;
        tick();
        reti = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
